// File: rtl/dmem_pkg.sv
// dmem_pkg: address map, status bit positions and UART state type shared by dmem_mmio
package dmem_pkg;
  localparam logic [31:0] MMIO_BASE   = 32'h1000_0000;
  localparam logic [31:0] MMIO_TXDATA = MMIO_BASE;
  localparam logic [31:0] MMIO_STATUS = MMIO_BASE + 32'h4;
  localparam logic [31:0] MMIO_MTIME  = MMIO_BASE + 32'h8;
  localparam logic [31:0] MMIO_TOHOST = MMIO_BASE + 32'h10;
  localparam int ST_TX_FULL = 0;
  localparam int ST_TX_IDLE = 1;
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_state_t;
endpackage

// File: rtl/dmem_mmio_uart_tx_ser.sv
// uart_tx_ser: 8N1 serializer that pops one byte per frame from an upstream FIFO
module uart_tx_ser
  import dmem_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       byte_valid,
  input  logic [7:0] byte_data,
  output logic       byte_pop,
  output logic       busy,
  output logic       tx
);
  localparam int BW = $clog2(CLKS_PER_BIT + 1);
  localparam logic [BW-1:0] LAST = BW'(CLKS_PER_BIT - 1);
  uart_state_t r_state, w_state;
  logic [BW-1:0] r_baud, w_baud;
  logic [2:0] r_bit, w_bit;
  logic [7:0] r_shift, w_shift;
  logic w_last;
  assign w_last = r_baud == LAST;
  assign busy = r_state != IDLE;
  assign tx = r_state == START ? 1'b0 : r_state == DATA ? r_shift[0] : 1'b1;
  // state, baud, bit and shifter registers; reset drops any in-flight byte
  always_ff @(posedge clk)
    if (!rst_n) begin
      r_state <= IDLE;
      r_baud  <= '0;
      r_bit   <= '0;
      r_shift <= '0;
    end else begin
      r_state <= w_state;
      r_baud  <= w_baud;
      r_bit   <= w_bit;
      r_shift <= w_shift;
    end
  // next state: every non-idle state lasts one full bit period
  always_comb begin
    w_state  = r_state;
    w_baud   = w_last ? '0 : r_baud + BW'(1);
    w_bit    = r_bit;
    w_shift  = r_shift;
    byte_pop = 1'b0;
    case (r_state)
      IDLE: begin
        w_baud   = '0;
        byte_pop = byte_valid;
        w_state  = byte_valid ? START : IDLE;
        w_shift  = byte_valid ? byte_data : r_shift;
      end
      START: w_state = w_last ? DATA : START;
      DATA: begin
        w_shift = w_last ? r_shift >> 1 : r_shift;
        w_bit   = w_last ? r_bit + 3'd1 : r_bit;
        w_state = w_last && r_bit == 3'd7 ? STOP : DATA;
      end
      STOP: w_state = w_last ? IDLE : STOP;
    endcase
  end
endmodule

// File: rtl/dmem_mmio.sv
// dmem_mmio: data RAM, UART console, cycle counter and tohost decode; DMEM_SIM_PRINT_EN echoes console/tohost writes
module dmem_mmio
  import dmem_pkg::*;
#(
  parameter int MEM_WORDS    = 256,
  parameter int FIFO_DEPTH   = 8,
  parameter int CLKS_PER_BIT = 868
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  input  logic        data_we,
  input  logic        data_re,
  output logic [31:0] data_rdata,
  output logic        uart_tx,
  output logic        halt,
  output logic [31:0] halt_code
);
  localparam int AW = $clog2(MEM_WORDS);
  localparam int PW = $clog2(FIFO_DEPTH);
  logic [31:0] r_mem [MEM_WORDS];
  logic [7:0] r_fifo [FIFO_DEPTH];
  logic [PW:0] r_wp, r_rp, w_cnt;
  logic [31:0] r_mtime, r_halt_code, w_status, w_word;
  logic r_halt;
  logic [AW-1:0] w_idx;
  logic w_ram, w_txd, w_sts, w_mtm, w_toh, w_full, w_empty, w_idle, w_push, w_pop, w_busy;
  assign w_word  = data_addr & ~32'h3;
  assign w_idx   = data_addr[AW+1:2];
  assign w_ram   = data_addr[31:10] == '0;
  assign w_txd   = w_word == MMIO_TXDATA;
  assign w_sts   = w_word == MMIO_STATUS;
  assign w_mtm   = w_word == MMIO_MTIME;
  assign w_toh   = w_word == MMIO_TOHOST;
  assign w_cnt   = r_wp - r_rp;
  assign w_full  = w_cnt[PW];
  assign w_empty = w_cnt == '0;
  assign w_idle  = w_empty && !w_busy;
  assign w_push  = data_we && w_txd && !w_full;
  assign halt      = r_halt;
  assign halt_code = r_halt_code;
  // status word assembled from named bit positions
  always_comb begin
    w_status = '0;
    w_status[ST_TX_FULL] = w_full;
    w_status[ST_TX_IDLE] = w_idle;
  end
  assign data_rdata = !data_re ? '0 :
                      w_ram    ? r_mem[w_idx] :
                      w_sts    ? w_status :
                      w_mtm    ? r_mtime :
                      w_toh    ? r_halt_code : '0;
  uart_tx_ser #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_ser (
    .clk       (clk),
    .rst_n     (rst_n),
    .byte_valid(!w_empty),
    .byte_data (r_fifo[r_rp[PW-1:0]]),
    .byte_pop  (w_pop),
    .busy      (w_busy),
    .tx        (uart_tx)
  );
  // RAM and FIFO storage arrays carry no reset
  always_ff @(posedge clk) begin
    if (data_we && w_ram) r_mem[w_idx] <= data_wdata;
    if (w_push) r_fifo[r_wp[PW-1:0]] <= data_wdata[7:0];
  end
  // FIFO pointers, cycle counter and sticky halt
  always_ff @(posedge clk)
    if (!rst_n) begin
      r_wp        <= '0;
      r_rp        <= '0;
      r_mtime     <= '0;
      r_halt      <= 1'b0;
      r_halt_code <= '0;
    end else begin
      r_mtime <= r_mtime + 32'd1;
      if (w_push) r_wp <= r_wp + (PW+1)'(1);
      if (w_pop) r_rp <= r_rp + (PW+1)'(1);
      if (data_we && w_toh) begin
        r_halt      <= 1'b1;
        r_halt_code <= data_wdata;
      end
    end
`ifdef DMEM_SIM_PRINT_EN
  // console echo of accepted bytes and tohost writes
  always_ff @(posedge clk)
    if (rst_n) begin
      if (w_push) $write("%c", data_wdata[7:0]);
      if (data_we && w_toh) $display("TOHOST code=0x%08x", data_wdata);
    end
`endif
endmodule

// File: tb/tb_dmem_mmio.sv
// tb_dmem_mmio: scoreboard bench for reads and UART frames of dmem_mmio
module tb_dmem_mmio;
  import dmem_pkg::*;
  localparam int CBP = 4;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic data_we = 1'b0;
  logic data_re = 1'b0;
  logic [31:0] data_addr = '0;
  logic [31:0] data_wdata = '0;
  logic [31:0] data_rdata, halt_code;
  logic uart_tx, halt;
  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] exp_q[$];
  string nm_q[$];
  logic [7:0] rx_q[$];
  dmem_mmio #(.MEM_WORDS(256), .FIFO_DEPTH(8), .CLKS_PER_BIT(CBP)) dut (
    .clk(clk), .rst_n(rst_n), .data_addr(data_addr), .data_wdata(data_wdata),
    .data_we(data_we), .data_re(data_re), .data_rdata(data_rdata),
    .uart_tx(uart_tx), .halt(halt), .halt_code(halt_code)
  );
  always #5 clk = ~clk;
  task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask
  function automatic logic [63:0] frame(input logic [7:0] b);
    logic [63:0] v;
    v = '0;
    for (int s = 0; s < 10; s++)
      for (int j = 0; j < CBP; j++)
        v[s*CBP+j] = s == 0 ? 1'b0 : s == 9 ? 1'b1 : b[s-1];
    return v;
  endfunction
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    data_addr = a;
    data_wdata = d;
    data_we = 1'b1;
    @(posedge clk);
    #1;
    data_we = 1'b0;
  endtask
  task automatic rd(input string nm, input logic [31:0] a, input logic [31:0] e);
    exp_q.push_back(e);
    nm_q.push_back(nm);
    data_addr = a;
    data_re = 1'b1;
    @(posedge clk);
    #1;
    data_re = 1'b0;
  endtask
  initial forever begin
    @(negedge clk);
    if (data_re) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_read: got %0h expected none", data_rdata);
      end else check(nm_q.pop_front(), data_rdata, exp_q.pop_front());
    end
  end
  initial forever begin
    @(negedge clk);
    if (rst_n && uart_tx === 1'b0) begin
      logic [63:0] got;
      logic ab;
      got = '0;
      ab = 1'b0;
      got[0] = uart_tx;
      for (int k = 1; k < 10*CBP; k++) begin
        @(negedge clk);
        if (!rst_n) begin
          ab = 1'b1;
          break;
        end
        got[k] = uart_tx;
      end
      if (!ab) begin
        if (rx_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_frame: got %0h expected none", got);
        end else check("uart_frame", got, frame(rx_q.pop_front()));
      end
    end
  end
  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
  initial begin
    cyc(3);
    check("rst_uart_tx", uart_tx, 1);
    check("rst_halt", halt, 0);
    check("rst_halt_code", halt_code, 0);
    rd("rst_status", MMIO_STATUS, 32'h2);
    rd("rst_mtime", MMIO_MTIME, 0);
    rst_n = 1'b1;
    cyc(99);
    rd("mtime_100th_edge", MMIO_MTIME, 32'd99);
    force dut.r_mtime = 32'hFFFF_FFFF;
    exp_q.push_back(32'hFFFF_FFFF);
    nm_q.push_back("mtime_forced");
    data_addr = MMIO_MTIME;
    data_re = 1'b1;
    @(negedge clk);
    #1;
    release dut.r_mtime;
    data_re = 1'b0;
    cyc(1);
    rd("mtime_wrap", MMIO_MTIME, 0);
    wr(32'h0, 32'h1E);
    rd("ram_roundtrip", 32'h0, 32'h1E);
    rd("unmapped_rd", 32'h2000_0000, 0);
    data_addr = 32'h0;
    @(negedge clk);
    check("rdata_no_re", data_rdata, 0);
    cyc(1);
    wr(32'h3FC, 32'hA5A5_0001);
    rd("ram_top_word", 32'h3FE, 32'hA5A5_0001);
    wr(32'h400, 32'h1234);
    rd("ram_not_aliased", 32'h0, 32'h1E);
    rd("unmapped_400", 32'h400, 0);
    exp_q.push_back(32'h1E);
    nm_q.push_back("rw_same_cycle");
    data_addr = 32'h0;
    data_wdata = 32'h55;
    data_we = 1'b1;
    data_re = 1'b1;
    cyc(1);
    data_we = 1'b0;
    data_re = 1'b0;
    rd("rw_after", 32'h0, 32'h55);
    rd("txdata_rd", MMIO_TXDATA, 0);
    rx_q.push_back(8'h41);
    wr(MMIO_TXDATA, 32'h41);
    @(negedge clk);
    check("tx_idle_after_push", uart_tx, 1);
    cyc(1);
    check("tx_start_latency", uart_tx, 0);
    rd("status_busy", MMIO_STATUS, 0);
    cyc(50);
    rd("status_after_frame", MMIO_STATUS, 32'h2);
    for (int i = 0; i < 10; i++) begin
      if (i < 9) rx_q.push_back(8'(8'h30 + i));
      wr(MMIO_TXDATA, 32'h30 + i);
      if (i == 7) rd("status_8th", MMIO_STATUS, 0);
      if (i == 8) rd("status_9th", MMIO_STATUS, 32'h1);
      if (i == 9) rd("status_10th", MMIO_STATUS, 32'h1);
    end
    cyc(420);
    rd("status_after_burst", MMIO_STATUS, 32'h2);
    check("frames_pending_burst", rx_q.size(), 0);
    wr(MMIO_TOHOST, 32'h1);
    check("halt_set", halt, 1);
    check("halt_code_set", halt_code, 1);
    rd("tohost_rd", MMIO_TOHOST, 32'h1);
    wr(32'h4, 32'hCAFE_F00D);
    rd("ram_during_halt", 32'h4, 32'hCAFE_F00D);
    wr(MMIO_TOHOST, 32'h2A);
    check("halt_sticky", halt, 1);
    check("halt_code_overwrite", halt_code, 32'h2A);
    wr(MMIO_TXDATA, 32'h55);
    wr(MMIO_TXDATA, 32'h66);
    cyc(9);
    check("tx_mid_frame", uart_tx, 0);
    rst_n = 1'b0;
    cyc(1);
    check("rst_mid_tx", uart_tx, 1);
    check("rst_halt_clear", halt, 0);
    check("rst_code_clear", halt_code, 0);
    rst_n = 1'b1;
    rd("status_after_rst", MMIO_STATUS, 32'h2);
    cyc(100);
    check("reads_pending", exp_q.size(), 0);
    check("frames_pending_end", rx_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
